adc3wire_responder: RTL and testbench

Synthesisable receiving end of the ADC 3-wire serial configuration interface. It oversamples the wire clock, data and strobe on the local system clock and assembles 32-bit frames, MSB first. Each frame holds a 12-bit header, a 4-bit address and 16-bit data. Valid frames are written into a 16x16 register file; malformed frames are flagged. Used as the ADC-side model in loopback/self-test builds and as the slave port of FPGA-emulated ADC boards.

---
 rtl/adc3wire_pkg.sv | 37 +++
 rtl/adc3wire_sync.sv | 33 +++
 rtl/adc3wire_responder.sv | 148 ++++++++++++++
 tb/tb_adc3wire_responder.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc3wire_pkg.sv
// Shared frame geometry, FSM state encoding and error codes for the ADC 3-wire responder.
// Latency: n/a (declarations and a pure combinational helper only).
// Backpressure: n/a.
package adc3wire_pkg;

   localparam int FRAME_BITS = 32;
   localparam int ADDR_W     = 4;
   localparam int DATA_W     = 16;
   localparam int HDR_W      = 12;
   localparam int CNT_W      = 6;
   localparam int NUM_REGS   = 1 << ADDR_W;

   // Bit counter stops one past a full frame so "too long" stays distinguishable.
   localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(FRAME_BITS + 1);

   typedef enum logic [1:0] {
      ST_ARM   = 2'd0,
      ST_IDLE  = 2'd1,
      ST_SHIFT = 2'd2
   } state_t;

   localparam logic [1:0] ERR_NONE  = 2'b00;
   localparam logic [1:0] ERR_SHORT = 2'b01;
   localparam logic [1:0] ERR_LONG  = 2'b10;
   localparam logic [1:0] ERR_HDR   = 2'b11;

   // Classify a finished frame; ERR_NONE means it may be committed.
   function automatic logic [1:0] frame_verdict(input logic [CNT_W-1:0] cnt,
                                                input logic [HDR_W-1:0] hdr,
                                                input logic [HDR_W-1:0] hdr_exp);
      if (cnt < CNT_W'(FRAME_BITS))      return ERR_SHORT;
      else if (cnt > CNT_W'(FRAME_BITS)) return ERR_LONG;
      else if (hdr != hdr_exp)           return ERR_HDR;
      else                               return ERR_NONE;
   endfunction

endpackage

// File: rtl/adc3wire_sync.sv
// Multi-flop synchroniser for one asynchronous wire, with single-cycle rise/fall pulses.
// Latency: SYNC_STAGES cycles to dout; edge pulses are combinational from the last two flops.
// Backpressure: none; the wire is sampled every cycle.
module adc3wire_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic wbs_clk_i,
   input  logic wbs_rst_n_i,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   dout_d;

   // Shift the raw wire through the synchroniser and keep one extra delayed copy for edges
   always_ff @(posedge wbs_clk_i or negedge wbs_rst_n_i) begin
      if (!wbs_rst_n_i) begin
         sync_q <= '0;
         dout_d <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         dout_d <= sync_q[SYNC_STAGES-1];
      end
   end

   assign dout = sync_q[SYNC_STAGES-1];
   assign rise = dout & ~dout_d;
   assign fall = ~dout & dout_d;

endmodule

// File: rtl/adc3wire_responder.sv
// ADC-side 3-wire config slave: assembles 32-bit MSB-first frames into a 16x16 register file.
// Latency: wr_valid/frame_err pulse SYNC_STAGES+1 cycles after the inactive strobe is first sampled; rd_data 1 cycle.
// Backpressure: none; the wire master cannot be stalled, results are pulses plus held registers.
module adc3wire_responder
   import adc3wire_pkg::*;
#(
   parameter int          SYNC_STAGES       = 2,
   parameter bit          STROBE_ACTIVE_LOW = 1'b1,
   parameter logic [11:0] HEADER_VALUE      = 12'h001
) (
   input  logic        wbs_clk_i,
   input  logic        wbs_rst_n_i,
   input  logic        adc3wire_clk,
   input  logic        adc3wire_data,
   input  logic        adc3wire_strobe,
   output logic        wr_valid,
   output logic [3:0]  wr_addr,
   output logic [15:0] wr_data,
   output logic        frame_err,
   output logic [1:0]  err_code,
   output logic [7:0]  frame_count,
   input  logic [3:0]  rd_addr,
   output logic [15:0] rd_data
);

   logic unused_sclk_lvl;
   logic unused_sclk_fall;
   logic unused_data_rise;
   logic unused_data_fall;

   logic sclk_rise;
   logic data_sync;
   logic strb_sync;
   logic strb_rise;
   logic strb_fall;

   // All three wires share one depth so data stays aligned with the clock edge that samples it.
   adc3wire_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
      .wbs_clk_i   (wbs_clk_i),
      .wbs_rst_n_i (wbs_rst_n_i),
      .din         (adc3wire_clk),
      .dout        (unused_sclk_lvl),
      .rise        (sclk_rise),
      .fall        (unused_sclk_fall)
   );

   adc3wire_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
      .wbs_clk_i   (wbs_clk_i),
      .wbs_rst_n_i (wbs_rst_n_i),
      .din         (adc3wire_data),
      .dout        (data_sync),
      .rise        (unused_data_rise),
      .fall        (unused_data_fall)
   );

   adc3wire_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_strb (
      .wbs_clk_i   (wbs_clk_i),
      .wbs_rst_n_i (wbs_rst_n_i),
      .din         (adc3wire_strobe),
      .dout        (strb_sync),
      .rise        (strb_rise),
      .fall        (strb_fall)
   );

   logic strb_act;
   logic strb_on;
   logic strb_off;

   assign strb_act = STROBE_ACTIVE_LOW ? ~strb_sync : strb_sync;
   assign strb_on  = STROBE_ACTIVE_LOW ? strb_fall : strb_rise;
   assign strb_off = STROBE_ACTIVE_LOW ? strb_rise : strb_fall;

   state_t                  state;
   logic [FRAME_BITS-1:0]   shift_reg;
   logic [CNT_W-1:0]        bit_cnt;
   logic [DATA_W-1:0]       regfile [NUM_REGS];
   logic [1:0]              verdict;

   assign verdict = frame_verdict(bit_cnt, shift_reg[FRAME_BITS-1 -: HDR_W], HEADER_VALUE);

   // Frame capture FSM, register file writes and registered result outputs
   always_ff @(posedge wbs_clk_i or negedge wbs_rst_n_i) begin
      if (!wbs_rst_n_i) begin
         state       <= ST_ARM;
         shift_reg   <= '0;
         bit_cnt     <= '0;
         wr_valid    <= 1'b0;
         wr_addr     <= '0;
         wr_data     <= '0;
         frame_err   <= 1'b0;
         err_code    <= ERR_NONE;
         frame_count <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            regfile[i] <= '0;
         end
      end else begin
         wr_valid  <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            // Never join a frame already in flight: wait for the strobe to go inactive first.
            ST_ARM: begin
               if (!strb_act) begin
                  state <= ST_IDLE;
               end
            end
            ST_IDLE: begin
               if (strb_on) begin
                  shift_reg <= '0;
                  bit_cnt   <= '0;
                  state     <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               // End of frame wins over a coincident sclk edge, which is dropped.
               if (strb_off) begin
                  state <= ST_IDLE;
                  if (verdict == ERR_NONE) begin
                     regfile[shift_reg[DATA_W +: ADDR_W]] <= shift_reg[DATA_W-1:0];
                     wr_addr     <= shift_reg[DATA_W +: ADDR_W];
                     wr_data     <= shift_reg[DATA_W-1:0];
                     wr_valid    <= 1'b1;
                     frame_count <= frame_count + 8'd1;
                  end else begin
                     frame_err <= 1'b1;
                     err_code  <= verdict;
                  end
               end else if (sclk_rise) begin
                  shift_reg <= {shift_reg[FRAME_BITS-2:0], data_sync};
                  if (bit_cnt != CNT_SAT) begin
                     bit_cnt <= bit_cnt + CNT_W'(1);
                  end
               end
            end
            default: state <= ST_ARM;
         endcase
      end
   end

   // Registered read port; a same-cycle write to rd_addr shows up one cycle later
   always_ff @(posedge wbs_clk_i or negedge wbs_rst_n_i) begin
      if (!wbs_rst_n_i) begin
         rd_data <= '0;
      end else begin
         rd_data <= regfile[rd_addr];
      end
   end

endmodule

// File: tb/tb_adc3wire_responder.sv
// Self-checking bench for adc3wire_responder: table vectors, corner sequences, randomized frames.
// Latency: checks the SYNC_STAGES+1 result latency on every frame.
// Backpressure: n/a.
module tb_adc3wire_responder;

   localparam int SYNC = 2;

   logic        wbs_clk_i = 1'b0;
   logic        wbs_rst_n_i;
   logic        adc3wire_clk;
   logic        adc3wire_data;
   logic        adc3wire_strobe;
   logic        wr_valid;
   logic [3:0]  wr_addr;
   logic [15:0] wr_data;
   logic        frame_err;
   logic [1:0]  err_code;
   logic [7:0]  frame_count;
   logic [3:0]  rd_addr;
   logic [15:0] rd_data;

   adc3wire_responder #(
      .SYNC_STAGES       (SYNC),
      .STROBE_ACTIVE_LOW (1'b1),
      .HEADER_VALUE      (12'h001)
   ) dut (
      .wbs_clk_i       (wbs_clk_i),
      .wbs_rst_n_i     (wbs_rst_n_i),
      .adc3wire_clk    (adc3wire_clk),
      .adc3wire_data   (adc3wire_data),
      .adc3wire_strobe (adc3wire_strobe),
      .wr_valid        (wr_valid),
      .wr_addr         (wr_addr),
      .wr_data         (wr_data),
      .frame_err       (frame_err),
      .err_code        (err_code),
      .frame_count     (frame_count),
      .rd_addr         (rd_addr),
      .rd_data         (rd_data)
   );

   always #5 wbs_clk_i = ~wbs_clk_i;

   int nvec = 0;
   int nmis = 0;
   int wv_cnt = 0;
   int fe_cnt = 0;
   int both_cnt = 0;

   // Pulse monitor, sampled away from the active edge
   always @(negedge wbs_clk_i) begin
      if (wr_valid)              wv_cnt++;
      if (frame_err)             fe_cnt++;
      if (wr_valid && frame_err) both_cnt++;
   end

   // Reference model: register file image plus the values the held outputs should show
   logic [15:0] sb [16];
   logic [3:0]  m_addr;
   logic [15:0] m_data;
   logic [1:0]  m_code;
   int          m_count;

   task automatic model_reset();
      for (int i = 0; i < 16; i++) sb[i] = 16'h0;
      m_addr = 4'h0; m_data = 16'h0; m_code = 2'b00; m_count = 0;
   endtask

   // A frame is the nbits low bits of 'bits', sent MSB first.
   task automatic model_frame(input logic [63:0] bits, input int nbits, output bit ok);
      ok = 1'b0;
      if (nbits < 32)                    m_code = 2'b01;
      else if (nbits > 32)               m_code = 2'b10;
      else if (bits[31:20] != 12'h001)   m_code = 2'b11;
      else begin
         ok = 1'b1;
         sb[bits[19:16]] = bits[15:0];
         m_addr  = bits[19:16];
         m_data  = bits[15:0];
         m_count = (m_count + 1) % 256;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge wbs_clk_i);
   endtask

   // Drive one frame with p wbs cycles per sclk phase, then watch a bounded window for the result.
   task automatic send_frame(input logic [63:0] bits, input int nbits, input int p,
                             output int lat, output logic [15:0] rd_at, output logic [15:0] rd_next);
      @(negedge wbs_clk_i);
      adc3wire_strobe = 1'b0;
      cyc(p);
      for (int i = nbits - 1; i >= 0; i--) begin
         adc3wire_data = bits[i];
         cyc(p);
         adc3wire_clk = 1'b1;
         cyc(p);
         adc3wire_clk = 1'b0;
      end
      cyc(p);
      adc3wire_strobe = 1'b1;
      lat = -1;
      rd_at = 16'hxxxx;
      rd_next = 16'hxxxx;
      for (int k = 1; k <= 12; k++) begin
         @(negedge wbs_clk_i);
         if (lat >= 0 && k == lat + 1) rd_next = rd_data;
         if ((wr_valid || frame_err) && lat < 0) begin
            lat = k;
            rd_at = rd_data;
         end
      end
   endtask

   // Model-checked frame: pulses, latency and all held outputs
   task automatic run_frame(input logic [63:0] bits, input int nbits, input int p, input string tag);
      int w0, f0, lat;
      bit ok;
      logic [15:0] r0, r1;
      w0 = wv_cnt;
      f0 = fe_cnt;
      send_frame(bits, nbits, p, lat, r0, r1);
      model_frame(bits, nbits, ok);
      check({tag, "_wr_pulses"},  32'(wv_cnt - w0), ok ? 32'd1 : 32'd0);
      check({tag, "_err_pulses"}, 32'(fe_cnt - f0), ok ? 32'd0 : 32'd1);
      check({tag, "_latency"},    32'(lat), 32'(SYNC + 1));
      check({tag, "_err_code"},   32'(err_code), 32'(m_code));
      check({tag, "_wr_addr"},    32'(wr_addr), 32'(m_addr));
      check({tag, "_wr_data"},    32'(wr_data), 32'(m_data));
      check({tag, "_count"},      32'(frame_count), 32'(m_count));
   endtask

   task automatic rd_check(input logic [3:0] a, input logic [15:0] exp, input string tag);
      @(negedge wbs_clk_i);
      rd_addr = a;
      @(negedge wbs_clk_i);
      check($sformatf("%s_rd%0d", tag, a), 32'(rd_data), 32'(exp));
   endtask

   task automatic do_reset();
      @(negedge wbs_clk_i);
      wbs_rst_n_i = 1'b0;
      model_reset();
      cyc(3);
      wbs_rst_n_i = 1'b1;
      cyc(6);
   endtask

   typedef struct {
      logic [63:0] bits;
      int          nbits;
      bit          exp_wr;
      logic [1:0]  exp_code;
      logic [3:0]  exp_addr;
      logic [15:0] exp_data;
      int          exp_cnt;
   } vec_t;

   vec_t tbl [10];

   initial begin
      int w0, f0, lat;
      bit ok;
      logic [15:0] r0, r1;
      logic [63:0] fb;
      logic [11:0] hdr;

      tbl[0] = '{64'h0_0015_BEEF, 32, 1'b1, 2'b00, 4'h5, 16'hBEEF, 1};
      tbl[1] = '{64'h0_000A_BCDE, 20, 1'b0, 2'b01, 4'h5, 16'hBEEF, 1};
      tbl[2] = '{64'h0_002B_7DDF, 33, 1'b0, 2'b10, 4'h5, 16'hBEEF, 1};
      tbl[3] = '{64'h0_0025_BEEF, 32, 1'b0, 2'b11, 4'h5, 16'hBEEF, 1};
      tbl[4] = '{64'h0,            0, 1'b0, 2'b01, 4'h5, 16'hBEEF, 1};
      tbl[5] = '{64'h0_000A_DF77, 31, 1'b0, 2'b01, 4'h5, 16'hBEEF, 1};
      tbl[6] = '{64'h0_001A_0001, 32, 1'b1, 2'b01, 4'hA, 16'h0001, 2};
      tbl[7] = '{64'h0_00F0_FFFF, 32, 1'b0, 2'b11, 4'hA, 16'h0001, 2};
      tbl[8] = '{64'h0_001F_FFFF, 32, 1'b1, 2'b11, 4'hF, 16'hFFFF, 3};
      tbl[9] = '{64'h0_0010_0000, 32, 1'b1, 2'b11, 4'h0, 16'h0000, 4};

      wbs_rst_n_i     = 1'b0;
      adc3wire_clk    = 1'b0;
      adc3wire_data   = 1'b0;
      adc3wire_strobe = 1'b1;
      rd_addr         = 4'h0;
      model_reset();
      cyc(3);
      check("rst_wr_valid",    32'(wr_valid), 32'd0);
      check("rst_frame_err",   32'(frame_err), 32'd0);
      check("rst_wr_addr",     32'(wr_addr), 32'd0);
      check("rst_wr_data",     32'(wr_data), 32'd0);
      check("rst_err_code",    32'(err_code), 32'd0);
      check("rst_frame_count", 32'(frame_count), 32'd0);
      check("rst_rd_data",     32'(rd_data), 32'd0);
      wbs_rst_n_i = 1'b1;
      cyc(6);

      // Table vectors at 16 wbs clocks per bit
      for (int i = 0; i < 10; i++) begin
         w0 = wv_cnt;
         f0 = fe_cnt;
         send_frame(tbl[i].bits, tbl[i].nbits, 8, lat, r0, r1);
         model_frame(tbl[i].bits, tbl[i].nbits, ok);
         check($sformatf("tbl%0d_wr_pulses", i),  32'(wv_cnt - w0), 32'(tbl[i].exp_wr));
         check($sformatf("tbl%0d_err_pulses", i), 32'(fe_cnt - f0), 32'(!tbl[i].exp_wr));
         check($sformatf("tbl%0d_latency", i),    32'(lat), 32'(SYNC + 1));
         check($sformatf("tbl%0d_err_code", i),   32'(err_code), 32'(tbl[i].exp_code));
         check($sformatf("tbl%0d_wr_addr", i),    32'(wr_addr), 32'(tbl[i].exp_addr));
         check($sformatf("tbl%0d_wr_data", i),    32'(wr_data), 32'(tbl[i].exp_data));
         check($sformatf("tbl%0d_count", i),      32'(frame_count), 32'(tbl[i].exp_cnt));
         if (i == 0) begin
            rd_check(4'h5, 16'hBEEF, "tbl0");
            rd_check(4'h4, 16'h0000, "tbl0");
            rd_check(4'h6, 16'h0000, "tbl0");
         end
      end
      for (int a = 0; a < 16; a++) rd_check(4'(a), sb[a], "tbl_rb");

      // Read of the address being written returns the old value first, then the new one
      @(negedge wbs_clk_i);
      rd_addr = 4'h5;
      send_frame(64'h0_0015_CAFE, 32, 8, lat, r0, r1);
      model_frame(64'h0_0015_CAFE, 32, ok);
      check("rdw_old_value", 32'(r0), 32'hBEEF);
      check("rdw_new_value", 32'(r1), 32'hCAFE);
      check("rdw_count",     32'(frame_count), 32'(m_count));

      // sclk noise with the strobe inactive must produce nothing
      w0 = wv_cnt;
      f0 = fe_cnt;
      for (int i = 0; i < 100; i++) begin
         adc3wire_data = 1'($urandom);
         cyc(3);
         adc3wire_clk = ~adc3wire_clk;
      end
      adc3wire_clk = 1'b0;
      cyc(12);
      check("noise_wr_pulses",  32'(wv_cnt - w0), 32'd0);
      check("noise_err_pulses", 32'(fe_cnt - f0), 32'd0);

      // Reset in the middle of a frame; the tail after release must be ignored
      fb = 64'h0_0017_1111;
      @(negedge wbs_clk_i);
      adc3wire_strobe = 1'b0;
      cyc(8);
      for (int i = 31; i >= 22; i--) begin
         adc3wire_data = fb[i];
         cyc(8); adc3wire_clk = 1'b1;
         cyc(8); adc3wire_clk = 1'b0;
      end
      wbs_rst_n_i = 1'b0;
      model_reset();
      cyc(3);
      check("midrst_count",  32'(frame_count), 32'd0);
      check("midrst_wr_data", 32'(wr_data), 32'd0);
      wbs_rst_n_i = 1'b1;
      w0 = wv_cnt;
      f0 = fe_cnt;
      cyc(5);
      for (int i = 21; i >= 0; i--) begin
         adc3wire_data = fb[i];
         cyc(8); adc3wire_clk = 1'b1;
         cyc(8); adc3wire_clk = 1'b0;
      end
      cyc(8);
      adc3wire_strobe = 1'b1;
      cyc(12);
      check("midrst_wr_pulses",  32'(wv_cnt - w0), 32'd0);
      check("midrst_err_pulses", 32'(fe_cnt - f0), 32'd0);
      rd_check(4'h7, 16'h0000, "midrst");
      run_frame(64'h0_0013_1234, 32, 8, "clean");
      rd_check(4'h3, 16'h1234, "clean");
      rd_check(4'h5, 16'h0000, "clean");

      // Randomized frames: lengths around 32, mostly good headers, varying sclk rate
      for (int i = 0; i < 24; i++) begin
         hdr = ($urandom_range(0, 3) != 0) ? 12'h001 : 12'($urandom);
         fb = {32'($urandom), hdr, 4'($urandom), 16'($urandom)};
         run_frame(fb, int'($urandom_range(30, 34)), int'($urandom_range(3, 6)),
                   $sformatf("rnd%0d", i));
      end
      for (int a = 0; a < 16; a++) rd_check(4'(a), sb[a], "rnd_rb");

      // 256 back-to-back valid frames at the fastest supported sclk wrap the counter to 0
      do_reset();
      check("stress_rst_count", 32'(frame_count), 32'd0);
      for (int i = 0; i < 256; i++) begin
         fb = {32'h0, 12'h001, 4'($urandom), 16'($urandom)};
         run_frame(fb, 32, 3, $sformatf("st%0d", i));
      end
      check("stress_wrap_count", 32'(frame_count), 32'd0);
      for (int a = 0; a < 16; a++) rd_check(4'(a), sb[a], "st_rb");

      check("never_both_pulses", 32'(both_cnt), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
